prog_delay_line: RTL
====================

// Module: prog_delay_line
// PURPOSE
//  Synthesisable, runtime-programmable transport delay for a WIDTH-bit sampled bus with a valid
//  qualifier: dout(t) = din(t-D-1). Ring buffer plus output register.
//  Replaces fixed #N delay modelling with clocked, parametrised delay for data/strobe alignment.
//  Optional inertial (glitch-reject) stage mirrors the pulse-swallowing behaviour of assign delays.
// PARAMETERS
//  WIDTH      8   data bus width, >=1
//  MAX_DLY    16  ring depth; legal D = 0..MAX_DLY-1, >=2
//  DEF_DLY    0   D after reset, must be < MAX_DLY
//  PULSE_REJ  2   inertial stage only: min stable run (cycles) accepted, >=1
//  DLY_W      localparam = $clog2(MAX_DLY)
// PORTS
//  clk       in   1      rising-edge clock, only clock
//  rst       in   1      synchronous, active-high reset
//  din       in   WIDTH  sample, written every cycle
//  din_vld   in   1      sample qualifier, stored alongside din
//  dly_sel   in   DLY_W+1 requested delay D, sampled only when dly_load=1
//  dly_load  in   1      1-cycle pulse: apply dly_sel
//  dout      out  WIDTH  delayed sample; 0 whenever dout_vld=0
//  dout_vld  out  1      delayed qualifier
//  busy      out  1      high while pipeline refills after a delay change
//  dly_cur   out  DLY_W  delay currently in force
// BEHAVIOUR
//  - Reset (sync, wins over everything): wp=0, all entry valid bits=0, dly_cur=DEF_DLY,
//    dout=0, dout_vld=0, busy=0; cnt=0.
//  - Every cycle: mem[wp]<= {din_vld,din}; wp<= wp+1 mod MAX_DLY (explicit wrap, any depth).
//  - Read index rp = (wp - dly_cur) mod MAX_DLY, same-cycle write bypassed for D=0;
//    output registered -> total latency D+1 cycles; D=0 gives 1-cycle register.
//  - dout_vld <= entry valid bit; dout <= entry data if valid else 0.
//  - dly_load=1: dly_cur <= min(dly_sel, MAX_DLY-1) (clamp, no error); all entry valid bits
//    cleared the same cycle; the sample written in the load cycle is kept (new regime).
//    First valid dout appears exactly new D+1 cycles after the load edge.
//  - busy: set on load, held for new D+1 cycles via down-counter, then 0; load while busy
//    restarts clear + count with the newest dly_sel. Load with same D still clears/refills.
//  - din_vld=0 samples propagate as dout_vld=0 holes after D+1 cycles, never lost or merged.
//  - No backpressure: stream is free-running; every input cycle maps to one output cycle.
// CONFIGURATION
//  INERTIAL_FILTER_EN defined: stage after output register; dout updates to a new value only
//    after the delayed stream shows that same value with vld=1 for PULSE_REJ consecutive
//    cycles; shorter runs are swallowed, dout holds last accepted value. Invalid sample resets
//    run counter; dout_vld = 1 only while accepted value equals current delayed value.
//    Latency D+PULSE_REJ. Load also clears filter (dout=0, dout_vld=0);
//    busy extends to D+PULSE_REJ.
//  Not defined: filter absent, pure transport delay, latency D+1, PULSE_REJ ignored.
// TESTING
//  1 rst held 2 cycles, din=8'hFF vld=1 -> dout=0, dout_vld=0, busy=0, dly_cur=DEF_DLY.
//  2 DEF_DLY=3, ramp din=1,2,3.. vld=1 -> dout=1 exactly 4 cycles after din=1; stream intact.
//  3 MAX_DLY=16, D=15, 40-cycle ramp -> no corruption across wp wrap; latency 16 throughout.
//  4 mid-stream load dly_sel=5 from D=2 -> dout_vld=0, busy=1 for 6 cycles; then load-cycle
//    sample; load dly_sel=31 -> dly_cur=15.
//  5 vld pattern 1,0,1,1,0 at D=4 -> identical pattern on dout_vld 5 cycles later, dout=0 holes.
//  6 INERTIAL_FILTER_EN, PULSE_REJ=3, D=0: din 5,5,5,9,9,5,5,5 -> dout 5; 2-cycle 9 rejected;
//    without macro 9 appears for 2 cycles.

Source files
------------

// File: rtl/prog_delay_line.sv
// prog_delay_line: runtime-programmable clocked delay for a WIDTH-bit bus with a valid qualifier.
// Transport behaviour: dout(t) = din(t-D-1). A ring buffer of MAX_DLY entries feeds a
// registered output stage.
//
// Optional build macro INERTIAL_FILTER_EN:
//   - adds a glitch-reject filter, fused with the output register;
//   - a new value is accepted only after it has been seen valid for PULSE_REJ consecutive cycles;
//   - latency becomes D+PULSE_REJ.
//
// Ports:
//   clk_i       rising-edge clock
//   rst_i       synchronous active-high reset (wins over everything)
//   din_i       input sample, written every cycle
//   din_vld_i   sample qualifier, stored with din_i
//   dly_sel_i   requested delay D; clamped to MAX_DLY-1; sampled only when dly_load_i=1
//   dly_load_i  single-cycle pulse that applies dly_sel_i
//   dout_o      delayed sample; in transport mode it is 0 whenever dout_vld_o=0
//   dout_vld_o  delayed qualifier
//   busy_o      high while the pipeline refills after a delay change
//   dly_cur_o   delay currently in force
module prog_delay_line #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_DLY   = 16,
  parameter int unsigned DEF_DLY   = 0,
  parameter int unsigned PULSE_REJ = 2,
  localparam int unsigned DLY_W    = $clog2(MAX_DLY)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             din_vld_i,
  input  logic [DLY_W:0]   dly_sel_i,
  input  logic             dly_load_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             dout_vld_o,
  output logic             busy_o,
  output logic [DLY_W-1:0] dly_cur_o
);

`ifdef INERTIAL_FILTER_EN
  localparam int unsigned ExtraCyc = PULSE_REJ - 1;
  localparam int unsigned RunW     = $clog2(PULSE_REJ + 1);
`else
  localparam int unsigned ExtraCyc = 0;
`endif
  localparam int unsigned CntW = $clog2(MAX_DLY + PULSE_REJ);

  logic [WIDTH-1:0]   mem_q [MAX_DLY];
  logic [MAX_DLY-1:0] vld_q, vld_d;
  logic [DLY_W-1:0]   wp_q, wp_d, dly_q, dly_d, dly_new, rp;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   dout_q, dout_d, rd_dat, s_dat;
  logic               dout_vld_q, dout_vld_d, rd_vld, s_vld;

  // Read side: the D=0 case bypasses the same-cycle write.
  always_comb begin
    if (dly_sel_i > (DLY_W+1)'(MAX_DLY - 1)) dly_new = DLY_W'(MAX_DLY - 1);
    else                                     dly_new = dly_sel_i[DLY_W-1:0];

    wp_d = (wp_q == DLY_W'(MAX_DLY - 1)) ? '0 : wp_q + DLY_W'(1);

    if (wp_q >= dly_q) rp = wp_q - dly_q;
    else               rp = DLY_W'({1'b0, wp_q} + (DLY_W+1)'(MAX_DLY) - {1'b0, dly_q});

    if (dly_q == '0) begin
      rd_vld = din_vld_i;
      rd_dat = din_i;
    end else begin
      rd_vld = vld_q[rp];
      rd_dat = mem_q[rp];
    end

    // On a load, the whole ring counts as empty except for the sample written this cycle.
    // That sample reaches the output on the next edge only when the new delay is 0.
    if (dly_load_i) begin
      s_vld = din_vld_i && (dly_new == '0);
      s_dat = din_i;
    end else begin
      s_vld = rd_vld;
      s_dat = rd_dat;
    end

    vld_d        = dly_load_i ? '0 : vld_q;
    vld_d[wp_q]  = din_vld_i;
    dly_d        = dly_load_i ? dly_new : dly_q;

    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (dly_load_i) begin
      busy_d = 1'b1;
      cnt_d  = CntW'(dly_new) + CntW'(ExtraCyc);
    end else if (busy_q) begin
      if (cnt_q == '0) busy_d = 1'b0;
      else             cnt_d  = cnt_q - CntW'(1);
    end
  end

`ifdef INERTIAL_FILTER_EN
  logic [RunW-1:0]  run_q, run_d, p_run;
  logic [WIDTH-1:0] run_val_q, run_val_d, acc_q, acc_d, p_acc;
  logic             acc_ok_q, acc_ok_d, p_ok;

  // A load clears the filter, so the previous-state view is forced empty during that cycle.
  always_comb begin
    p_run = dly_load_i ? '0 : run_q;
    p_acc = dly_load_i ? '0 : acc_q;
    p_ok  = dly_load_i ? 1'b0 : acc_ok_q;

    run_val_d = s_dat;
    if (!s_vld)                                  run_d = '0;
    else if (p_run != '0 && s_dat == run_val_q) run_d = (p_run < RunW'(PULSE_REJ)) ?
                                                         p_run + RunW'(1) : p_run;
    else                                         run_d = RunW'(1);

    if (s_vld && run_d >= RunW'(PULSE_REJ)) begin
      acc_d    = s_dat;
      acc_ok_d = 1'b1;
    end else begin
      acc_d    = p_acc;
      acc_ok_d = p_ok;
    end

    dout_d     = acc_d;
    dout_vld_d = acc_ok_d && s_vld && (s_dat == acc_d);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      run_q     <= '0;
      run_val_q <= '0;
      acc_q     <= '0;
      acc_ok_q  <= 1'b0;
    end else begin
      run_q     <= run_d;
      run_val_q <= run_val_d;
      acc_q     <= acc_d;
      acc_ok_q  <= acc_ok_d;
    end
  end
`else
  always_comb begin
    dout_d     = s_vld ? s_dat : '0;
    dout_vld_d = s_vld;
  end
`endif

  // Data payload needs no reset; validity is tracked separately in vld_q.
  always_ff @(posedge clk_i) begin
    if (!rst_i) mem_q[wp_q] <= din_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp_q       <= '0;
      vld_q      <= '0;
      dly_q      <= DLY_W'(DEF_DLY);
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      vld_q      <= vld_d;
      dly_q      <= dly_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
    end
  end

  assign dout_o     = dout_q;
  assign dout_vld_o = dout_vld_q;
  assign busy_o     = busy_q;
  assign dly_cur_o  = dly_q;

endmodule
